// File: rtl/subtractor_pkg.sv
// Shared constants for the Phase 1 ALU subtractor: datapath width, CLA grouping
// and the bit positions of the ALU status flags.
package subtractor_pkg;

    localparam int WIDTH  = 32;
    localparam int GROUP  = 4;
    localparam int GROUPS = WIDTH / GROUP;

    localparam int NUM_FLAGS = 4;

    typedef enum int {
        FLAG_ZERO   = 0,
        FLAG_NEG    = 1,
        FLAG_BORROW = 2,
        FLAG_OVF    = 3
    } flag_idx_e;

endpackage

// File: rtl/cla_adder_32.sv
// 32-bit carry-lookahead adder: eight 4-bit lookahead groups chained through
// their group generate/propagate terms.
module cla_adder_32
    import subtractor_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [GROUPS:0]   grp_c;
    logic [GROUPS-1:0] grp_g;
    logic [GROUPS-1:0] grp_p;

    assign grp_c[0] = cin;

    for (genvar k = 0; k < GROUPS; k++) begin : g_grp
        logic [GROUP-1:0] g;
        logic [GROUP-1:0] p;
        logic [GROUP-1:0] c;

        assign g = a[k*GROUP +: GROUP] & b[k*GROUP +: GROUP];
        assign p = a[k*GROUP +: GROUP] ^ b[k*GROUP +: GROUP];

        // NOTE: the datapath is built only from continuous assigns, so no latch can be inferred.
        assign c[0] = grp_c[k];
        assign c[1] = g[0] | (p[0] & c[0]);
        assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                    | (p[2] & p[1] & p[0] & c[0]);

        assign sum[k*GROUP +: GROUP] = p ^ c;

        assign grp_g[k] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                        | (p[3] & p[2] & p[1] & g[0]);
        assign grp_p[k] = &p;

        // Carry out of this group depends only on the group terms and its carry-in.
        assign grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
    end

    assign cout = grp_c[GROUPS];

endmodule

// File: rtl/subtractor.sv
// Two's-complement subtractor (A - B = A + ~B + 1) with combinational status
// flags and a sticky signed-overflow register.
module subtractor
    import subtractor_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Result,
    output logic             Borrow,
    output logic             Overflow,
    output logic             Zero,
    output logic             Negative,
    output logic             OvfSticky
);

    logic [WIDTH-1:0]     b_inv;
    logic                 carry_out;
    logic [NUM_FLAGS-1:0] flags;

    assign b_inv = ~B;

    cla_adder_32 u_adder (
        .a    (A),
        .b    (b_inv),
        .cin  (1'b1),
        .sum  (Result),
        .cout (carry_out)
    );

    // No carry out of A + ~B + 1 means the unsigned minuend was smaller.
    assign flags[FLAG_ZERO]   = (Result == '0);
    assign flags[FLAG_NEG]    = Result[WIDTH-1];
    assign flags[FLAG_BORROW] = ~carry_out;
    assign flags[FLAG_OVF]    = (A[WIDTH-1] != B[WIDTH-1]) && (Result[WIDTH-1] != A[WIDTH-1]);

    assign Zero     = flags[FLAG_ZERO];
    assign Negative = flags[FLAG_NEG];
    assign Borrow   = flags[FLAG_BORROW];
    assign Overflow = flags[FLAG_OVF];

    // NOTE: non-blocking assignment so the register samples the pre-edge Overflow value.
    always_ff @(posedge clock) begin
        if (reset) begin
            OvfSticky <= 1'b0;
        end else if (Overflow) begin
            OvfSticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_subtractor.sv
// Self-checking bench for subtractor: directed corner cases then random operands,
// compared against an arithmetic reference model.
module tb_subtractor;

    logic        clock;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] Result;
    logic        Borrow;
    logic        Overflow;
    logic        Zero;
    logic        Negative;
    logic        OvfSticky;

    int compared   = 0;
    int mismatched = 0;

    logic ref_sticky;

    subtractor dut (
        .clock     (clock),
        .reset     (reset),
        .A         (A),
        .B         (B),
        .Result    (Result),
        .Borrow    (Borrow),
        .Overflow  (Overflow),
        .Zero      (Zero),
        .Negative  (Negative),
        .OvfSticky (OvfSticky)
    );

    initial clock = 1'b0;
    always #20 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, expected run to finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic check_comb(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp_res;
        longint      sdiff;
        logic        exp_ovf;
        exp_res = a - b;
        sdiff   = longint'($signed(a)) - longint'($signed(b));
        exp_ovf = (sdiff > 64'sd2147483647) || (sdiff < -64'sd2147483648);
        check("result",   Result,           exp_res);
        check("borrow",   {31'd0, Borrow},   {31'd0, a < b});
        check("overflow", {31'd0, Overflow}, {31'd0, exp_ovf});
        check("zero",     {31'd0, Zero},     {31'd0, exp_res == 32'd0});
        check("negative", {31'd0, Negative}, {31'd0, $signed(exp_res) < 0});
    endtask

    // Drive operands away from the active edge, check flags 10 ns later,
    // then check the sticky flag just after the following rising edge.
    task automatic step(input logic [31:0] a, input logic [31:0] b, input logic r);
        longint sdiff;
        @(negedge clock);
        A = a;
        B = b;
        reset = r;
        #10;
        check_comb(a, b);
        sdiff = longint'($signed(a)) - longint'($signed(b));
        @(posedge clock);
        if (r)
            ref_sticky = 1'b0;
        else if ((sdiff > 64'sd2147483647) || (sdiff < -64'sd2147483648))
            ref_sticky = 1'b1;
        #1;
        check("ovf_sticky", {31'd0, OvfSticky}, {31'd0, ref_sticky});
    endtask

    initial begin
        A = 32'd0;
        B = 32'd0;
        reset = 1'b1;
        ref_sticky = 1'b0;

        step(32'h0000_0000, 32'h0000_0000, 1'b1);
        check("reset_sticky", {31'd0, OvfSticky}, 32'd0);

        step(32'h0000_0000, 32'h0000_0000, 1'b0);
        check("zero_vec", {31'd0, Zero}, 32'd1);
        step(32'h0000_002D, 32'h0000_0022, 1'b0);
        check("45_minus_34", Result, 32'h0000_000B);
        step(32'h0000_0022, 32'h0000_002D, 1'b0);
        check("34_minus_45", Result, 32'hFFFF_FFF5);
        step(32'h0000_0000, 32'h0000_0001, 1'b0);
        check("0_minus_1_borrow", {31'd0, Borrow}, 32'd1);
        step(32'h0000_0005, 32'h0000_0005, 1'b0);
        check("5_minus_5_borrow", {31'd0, Borrow}, 32'd0);
        step(32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
        check("wrap_0_minus_ff", Result, 32'h0000_0001);
        step(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("wrap_7f_minus_ff", Result, 32'h8000_0000);
        step(32'h0000_002D, 32'h0000_0022, 1'b1);

        step(32'h8000_0000, 32'h0000_0001, 1'b0);
        check("ovf_result", Result, 32'h7FFF_FFFF);
        check("sticky_set", {31'd0, OvfSticky}, 32'd1);
        step(32'h0000_002D, 32'h0000_0022, 1'b0);
        check("sticky_hold", {31'd0, OvfSticky}, 32'd1);

        // Reset wins over a simultaneous overflow; the datapath is unaffected.
        step(32'h8000_0000, 32'h0000_0001, 1'b1);
        check("sticky_reset_priority", {31'd0, OvfSticky}, 32'd0);
        check("result_during_reset", Result, 32'h7FFF_FFFF);
        step(32'h0000_002D, 32'h0000_0022, 1'b0);
        check("sticky_stays_clear", {31'd0, OvfSticky}, 32'd0);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = ra;
                1: ra = {1'b1, ra[30:0]};
                2: rb = {1'b0, rb[30:0]};
                default: ;
            endcase
            step(ra, rb, ($urandom_range(0, 15) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
